// File: rtl/mci_boot_seqr_if.sv
// rtl/mci_boot_seqr_if.sv - boot sequencer handshake bundle
// master = register block / subsystem side, slave = the sequencer.
interface mci_boot_seqr_if;
  logic       mci_boot_seq_brkpoint;
  logic       mci_bootfsm_go;
  logic       fc_opt_init;
  logic       fc_opt_done;
  logic       lc_init;
  logic       lc_done;
  logic       pll_lock;
  logic       mcu_rst_b;
  logic       cptra_rst_release;
  logic       cptra_rst_b;
  logic       hitless_update_req;
  logic       mcu_halt_ack;
  logic [3:0] boot_fsm_state;
  logic       boot_err;

  modport master (
    output mci_boot_seq_brkpoint, mci_bootfsm_go, fc_opt_done, lc_done, pll_lock,
           cptra_rst_release, hitless_update_req, mcu_halt_ack,
    input  fc_opt_init, lc_init, mcu_rst_b, cptra_rst_b, boot_fsm_state, boot_err
  );

  modport slave (
    input  mci_boot_seq_brkpoint, mci_bootfsm_go, fc_opt_done, lc_done, pll_lock,
           cptra_rst_release, hitless_update_req, mcu_halt_ack,
    output fc_opt_init, lc_init, mcu_rst_b, cptra_rst_b, boot_fsm_state, boot_err
  );
endinterface

// File: rtl/mci_boot_seqr.sv
// rtl/mci_boot_seqr.sv - MCI cold boot and MCU hitless update sequencer
// Outputs are decoded from the next state so they change on the same edge as the state.
module mci_boot_seqr #(
  parameter int unsigned MCU_UPDATE_RESET_CYCLES = 10,
  parameter int unsigned WAIT_TIMEOUT_CYCLES     = 1024
) (
  input  logic            clk,
  input  logic            mci_rst_b,
  mci_boot_seqr_if.slave  bus
);

  typedef enum logic [3:0] {
    BOOT_IDLE        = 4'h0,
    BOOT_FABRIC      = 4'h1,
    BOOT_OTP_FC      = 4'h2,
    BOOT_LCC         = 4'h3,
    BOOT_MCU         = 4'h4,
    BOOT_PLL         = 4'h5,
    BOOT_WAIT_CPTRA  = 4'h6,
    BOOT_CPTRA       = 4'h7,
    BOOT_WAIT_UPDATE = 4'h8,
    BOOT_RST_MCU     = 4'h9
  } mci_boot_fsm_state_e;

  localparam int unsigned WAIT_W = (WAIT_TIMEOUT_CYCLES == 0) ? 1 : $clog2(WAIT_TIMEOUT_CYCLES + 1);
  localparam int unsigned UPD_W  = $clog2(MCU_UPDATE_RESET_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_TIMEOUT_CYCLES);
  localparam logic [UPD_W-1:0]  UPD_LAST = UPD_W'(MCU_UPDATE_RESET_CYCLES - 1);

  mci_boot_fsm_state_e r_state;
  mci_boot_fsm_state_e w_next;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [UPD_W-1:0]    r_upd_cnt;
  logic                r_fc_opt_init;
  logic                r_lc_init;
  logic                r_mcu_rst_b;
  logic                r_cptra_rst_b;
  logic                r_boot_err;
  logic                w_waiting;
  logic                w_timeout;
  logic                w_illegal;

  always_comb begin
    w_next = r_state;
    case (r_state)
      BOOT_IDLE:        w_next = BOOT_FABRIC;
      BOOT_FABRIC:      if (!bus.mci_boot_seq_brkpoint || bus.mci_bootfsm_go) w_next = BOOT_OTP_FC;
      BOOT_OTP_FC:      if (bus.fc_opt_done)        w_next = BOOT_LCC;
      BOOT_LCC:         if (bus.lc_done)            w_next = BOOT_MCU;
      BOOT_MCU:         w_next = BOOT_PLL;
      BOOT_PLL:         if (bus.pll_lock)           w_next = BOOT_WAIT_CPTRA;
      BOOT_WAIT_CPTRA:  if (bus.cptra_rst_release)  w_next = BOOT_CPTRA;
      BOOT_CPTRA:       if (bus.hitless_update_req) w_next = BOOT_WAIT_UPDATE;
      BOOT_WAIT_UPDATE: if (bus.mcu_halt_ack)       w_next = BOOT_RST_MCU;
      BOOT_RST_MCU:     if (r_upd_cnt == UPD_LAST)  w_next = BOOT_CPTRA;
      default:          w_next = BOOT_IDLE;
    endcase
  end

  assign w_waiting = (r_state == BOOT_OTP_FC) || (r_state == BOOT_LCC) ||
                     (r_state == BOOT_PLL)    || (r_state == BOOT_WAIT_UPDATE);
  assign w_timeout = (WAIT_TIMEOUT_CYCLES != 0) && (r_wait_cnt == WAIT_MAX);
  assign w_illegal = (r_state > BOOT_RST_MCU);

  // Illegal encodings recover exactly like a reset so every output is safe immediately.
  always_ff @(posedge clk) begin
    if (!mci_rst_b || w_illegal) begin
      r_state       <= BOOT_IDLE;
      r_wait_cnt    <= '0;
      r_upd_cnt     <= '0;
      r_fc_opt_init <= 1'b0;
      r_lc_init     <= 1'b0;
      r_mcu_rst_b   <= 1'b0;
      r_cptra_rst_b <= 1'b0;
      r_boot_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wait_cnt <= '0;
        r_upd_cnt  <= '0;
      end else begin
        if (w_waiting && (r_wait_cnt != WAIT_MAX)) r_wait_cnt <= r_wait_cnt + 1'b1;
        if (r_state == BOOT_RST_MCU) r_upd_cnt <= r_upd_cnt + 1'b1;
      end
      if (w_timeout) r_boot_err <= 1'b1;
      r_fc_opt_init <= (w_next == BOOT_OTP_FC);
      r_lc_init     <= (w_next == BOOT_LCC);
      r_mcu_rst_b   <= (w_next == BOOT_MCU) || (w_next == BOOT_PLL) || (w_next == BOOT_WAIT_CPTRA) ||
                       (w_next == BOOT_CPTRA) || (w_next == BOOT_WAIT_UPDATE);
      r_cptra_rst_b <= (w_next == BOOT_CPTRA) || (w_next == BOOT_WAIT_UPDATE) ||
                       (w_next == BOOT_RST_MCU);
    end
  end

  assign bus.boot_fsm_state = r_state;
  assign bus.fc_opt_init    = r_fc_opt_init;
  assign bus.lc_init        = r_lc_init;
  assign bus.mcu_rst_b      = r_mcu_rst_b;
  assign bus.cptra_rst_b    = r_cptra_rst_b;
  assign bus.boot_err       = r_boot_err;

endmodule

// File: doc/mci_boot_seqr.md
Name: mci_boot_seqr

Overview:
- MCI boot sequencer FSM, driven by the `mci_pkg` state enum `mci_boot_fsm_state_e`.
- Walks the subsystem through cold boot in order: fabric release, fuse controller (OTP) init, lifecycle controller (LCC) init, MCU reset release, PLL lock, Caliptra reset release.
- After boot it handles MCU hitless firmware update by re-pulsing MCU reset for a fixed number of cycles.
- Sits between the MCI register block (breakpoint/go/release/update requests) and the reset and init controls of the MCU, Caliptra, OTP and LCC.

Parameters:
- MCU_UPDATE_RESET_CYCLES, 10, number of cycles `mcu_rst_b` is held low during a hitless update (legal range 1..255). Matches `mci_pkg::MCI_MCU_UPDATE_RESET_CYLES`.
- WAIT_TIMEOUT_CYCLES, 1024, cycles allowed in any handshake-wait state before `boot_err` is flagged. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- mci_rst_b  in  1  reset; synchronous to clk, active-low
- mci_boot_seq_brkpoint  in  1  when high, FSM halts in BOOT_FABRIC until `mci_bootfsm_go`
- mci_bootfsm_go  in  1  single-cycle pulse that releases the breakpoint
- fc_opt_init  out  1  fuse controller init request (level)
- fc_opt_done  in  1  fuse controller init complete
- lc_init  out  1  lifecycle controller init request (level)
- lc_done  in  1  lifecycle controller init complete
- pll_lock  in  1  PLL locked
- mcu_rst_b  out  1  MCU reset, active-low
- cptra_rst_release  in  1  MCU firmware request to release Caliptra (pulse or level)
- cptra_rst_b  out  1  Caliptra reset, active-low
- hitless_update_req  in  1  pulse: MCU firmware update staged
- mcu_halt_ack  in  1  MCU quiesced, safe to reset
- boot_fsm_state  out  4  current state (`mci_boot_fsm_state_e` encoding)
- boot_err  out  1  sticky handshake-timeout flag

Behaviour:
- All outputs are registered; every output updates on the same edge as the state register. All inputs are sampled only on rising edges of clk.
- Reset (`mci_rst_b`=0 at an edge), taken at any time including mid-sequence or mid-update:
  - state=BOOT_IDLE, `boot_fsm_state`=4'h0
  - `mcu_rst_b`=0, `cptra_rst_b`=0, `fc_opt_init`=0, `lc_init`=0, `boot_err`=0
  - all counters cleared
- Transitions (one per clock maximum):
  - BOOT_IDLE -> BOOT_FABRIC unconditionally on the next edge.
  - BOOT_FABRIC -> BOOT_OTP_FC when `mci_boot_seq_brkpoint`=0, or when `mci_bootfsm_go`=1. A go pulse while no breakpoint is set is harmless.
  - BOOT_OTP_FC: `fc_opt_init`=1 for the whole state. -> BOOT_LCC when `fc_opt_done`=1.
  - BOOT_LCC: `lc_init`=1 for the whole state. -> BOOT_MCU when `lc_done`=1.
  - BOOT_MCU: `mcu_rst_b`=1. -> BOOT_PLL next edge (single-cycle state).
  - BOOT_PLL -> BOOT_WAIT_CPTRA when `pll_lock`=1.
  - BOOT_WAIT_CPTRA -> BOOT_CPTRA when `cptra_rst_release`=1. `cptra_rst_b` goes 1 on entry to BOOT_CPTRA.
  - BOOT_CPTRA: steady state. -> BOOT_WAIT_UPDATE on `hitless_update_req`=1.
  - BOOT_WAIT_UPDATE -> BOOT_RST_MCU when `mcu_halt_ack`=1.
  - BOOT_RST_MCU: `mcu_rst_b`=0 for exactly MCU_UPDATE_RESET_CYCLES cycles, then -> BOOT_CPTRA with `mcu_rst_b`=1.
- Reset output levels by state:
  - `mcu_rst_b`=1 in MCU, PLL, WAIT_CPTRA, CPTRA, WAIT_UPDATE; 0 elsewhere.
  - `cptra_rst_b`=1 in CPTRA, WAIT_UPDATE, RST_MCU; 0 elsewhere. Caliptra is never reset by a hitless update.
- Ignored inputs:
  - `hitless_update_req` outside BOOT_CPTRA.
  - done/lock/release/ack inputs outside their wait state.
  - a second update request during WAIT_UPDATE/RST_MCU (not queued).
- Timeout:
  - A wait counter clears on every state change and increments each cycle spent in OTP_FC, LCC, PLL or WAIT_UPDATE.
  - When it reaches WAIT_TIMEOUT_CYCLES (non-zero), `boot_err` sets on the next edge.
  - `boot_err` is sticky until reset. The FSM keeps waiting and does not abort.
  - The counter saturates; it never wraps.
- Illegal state encodings (4'hA-4'hF) go to BOOT_IDLE on the next edge with all outputs at reset values.
- Counter widths are sized with $clog2 from the parameters. No arithmetic overflow is reachable.

Test Plan:
- Cold boot, brkpoint=0, done/lock/release asserted 3 cycles after each request -> states visited 0,1,2,3,4,5,6,7 in order; `mcu_rst_b` rises on entry to state 4; `cptra_rst_b` rises on entry to state 7; `boot_err`=0.
- brkpoint=1 -> FSM holds at 4'h1 for 50 cycles; go pulse -> 4'h2 on the next edge; `fc_opt_init`=1 from that edge.
- Hitless update in BOOT_CPTRA: req pulse, ack 5 cycles later -> state 8 then 9; `mcu_rst_b` low exactly 10 cycles; return to 7; `cptra_rst_b` stays 1 throughout.
- WAIT_TIMEOUT_CYCLES=16, `fc_opt_done` withheld -> `boot_err`=1 after 16 cycles in state 2; `fc_opt_done`=1 afterwards -> advances to 3 with `boot_err` still 1.
- Reset asserted while in BOOT_RST_MCU (cycle 4 of 10) -> next edge state=0, all outputs at reset values; released -> a clean cold boot repeats.
- `hitless_update_req` pulsed in state 5, and `lc_done` pulsed in state 2 -> both ignored; FSM advances only on the matching inputs.
